// File: rtl/cv_pad_reader.sv
// ============================================================================
// Module   : cv_pad_reader
// Brief    : Scans a ColecoVision hand controller (joystick + keypad) and emits
//            a debounced 20-bit joystick bitmap. Optional spinner: CV_PAD_SPINNER_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv_pad_reader #(
    parameter logic [3:0] SETTLE_CYC = 4'd8,
    parameter int         DEBOUNCE_N = 3
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        ce_i,
    input  logic        enable_i,
    input  logic [3:0]  pad_d_i,
    input  logic        pad_fire_i,
    output logic        sel_p8_n_o,
    output logic        sel_p5_n_o,
    output logic [19:0] joy_o,
    output logic        valid_o
`ifdef CV_PAD_SPINNER_EN
    ,
    input  logic [1:0]  pad_q_i,
    output logic [7:0]  spin_o
`endif
);

    localparam int             CW          = $clog2(DEBOUNCE_N + 1);
    localparam logic [CW-1:0]  c_deb_n     = CW'(DEBOUNCE_N);
    localparam logic [3:0]     c_settle_lt = SETTLE_CYC - 4'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAP_J = 3'd1,
        S_SEL_J = 3'd2,
        S_GAP_K = 3'd3,
        S_SEL_K = 3'd4,
        S_EVAL  = 3'd5
    } t_state;

    t_state        r_state;
    logic [3:0]    r_settle;
    logic [19:0]   r_cand;
    logic [19:0]   r_prev;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic [3:0]    r_d_meta;
    logic [3:0]    r_d_sync;
    logic          r_fire_meta;
    logic          r_fire_sync;

    // Keypad code -> {blue, purple, 9..0, #, *}; unknown codes read as no key.
    function automatic logic [13:0] f_decode(input logic [3:0] code);
        logic [13:0] k;
        k = 14'd0;
        case (code)
            4'b0011: k[2]  = 1'b1;
            4'b1110: k[3]  = 1'b1;
            4'b1101: k[4]  = 1'b1;
            4'b0110: k[5]  = 1'b1;
            4'b0001: k[6]  = 1'b1;
            4'b1001: k[7]  = 1'b1;
            4'b0111: k[8]  = 1'b1;
            4'b1100: k[9]  = 1'b1;
            4'b1000: k[10] = 1'b1;
            4'b1011: k[11] = 1'b1;
            4'b1010: k[0]  = 1'b1;
            4'b0101: k[1]  = 1'b1;
            4'b0100: k[12] = 1'b1;
            4'b0010: k[13] = 1'b1;
            default: k = 14'd0;
        endcase
        return k;
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_d_meta    <= 4'hF;
            r_d_sync    <= 4'hF;
            r_fire_meta <= 1'b1;
            r_fire_sync <= 1'b1;
        end else begin
            r_d_meta    <= pad_d_i;
            r_d_sync    <= r_d_meta;
            r_fire_meta <= pad_fire_i;
            r_fire_sync <= r_fire_meta;
        end
    end

    always_comb begin
        w_cnt_next = CW'(1);
        if (r_cand == r_prev) begin
            w_cnt_next = (r_cnt >= c_deb_n) ? c_deb_n : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= S_IDLE;
            r_settle   <= 4'd0;
            r_cand     <= 20'd0;
            r_prev     <= 20'd0;
            r_cnt      <= '0;
            sel_p8_n_o <= 1'b1;
            sel_p5_n_o <= 1'b1;
            joy_o      <= 20'd0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (ce_i) begin
                if (!enable_i) begin
                    r_state    <= S_IDLE;
                    sel_p8_n_o <= 1'b1;
                    sel_p5_n_o <= 1'b1;
                    joy_o      <= 20'd0;
                    r_cnt      <= '0;
                    valid_o    <= |joy_o;
                end else begin
                    case (r_state)
                        S_IDLE: r_state <= S_GAP_J;
                        S_GAP_J: begin
                            r_state    <= S_SEL_J;
                            sel_p8_n_o <= 1'b0;
                            r_settle   <= 4'd0;
                        end
                        S_SEL_J: begin
                            if (r_settle == c_settle_lt) begin
                                r_cand[4:0] <= {~r_fire_sync, ~r_d_sync};
                                sel_p8_n_o  <= 1'b1;
                                r_state     <= S_GAP_K;
                            end else begin
                                r_settle <= r_settle + 4'd1;
                            end
                        end
                        S_GAP_K: begin
                            r_state    <= S_SEL_K;
                            sel_p5_n_o <= 1'b0;
                            r_settle   <= 4'd0;
                        end
                        S_SEL_K: begin
                            if (r_settle == c_settle_lt) begin
                                r_cand[19:5] <= {f_decode(r_d_sync), ~r_fire_sync};
                                sel_p5_n_o   <= 1'b1;
                                r_state      <= S_EVAL;
                            end else begin
                                r_settle <= r_settle + 4'd1;
                            end
                        end
                        S_EVAL: begin
                            r_prev  <= r_cand;
                            r_cnt   <= w_cnt_next;
                            r_state <= S_GAP_J;
                            if (w_cnt_next == c_deb_n && r_cand != joy_o) begin
                                joy_o   <= r_cand;
                                valid_o <= 1'b1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

`ifdef CV_PAD_SPINNER_EN
    logic [1:0] r_q_meta;
    logic [1:0] r_q_sync;
    logic [1:0] r_q_prev;
    logic [7:0] r_acc;
    logic [1:0] w_pos_cur;
    logic [1:0] w_pos_prev;
    logic [1:0] w_pos_diff;
    logic       w_step_up;
    logic       w_step_dn;
    logic       w_eval_ce;
    logic [7:0] w_acc_sat;

    // Gray position 00,01,11,10 -> 0,1,2,3; a one-step difference gives direction.
    assign w_pos_cur  = {r_q_sync[1], r_q_sync[1] ^ r_q_sync[0]};
    assign w_pos_prev = {r_q_prev[1], r_q_prev[1] ^ r_q_prev[0]};
    assign w_pos_diff = w_pos_cur - w_pos_prev;
    assign w_step_up  = (w_pos_diff == 2'd1);
    assign w_step_dn  = (w_pos_diff == 2'd3);
    assign w_eval_ce  = ce_i && enable_i && (r_state == S_EVAL);

    always_comb begin
        w_acc_sat = r_acc;
        if (w_step_up && r_acc != 8'h7F) begin
            w_acc_sat = r_acc + 8'd1;
        end else if (w_step_dn && r_acc != 8'h80) begin
            w_acc_sat = r_acc - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_q_meta <= 2'b00;
            r_q_sync <= 2'b00;
            r_q_prev <= 2'b00;
            r_acc    <= 8'd0;
            spin_o   <= 8'd0;
        end else begin
            r_q_meta <= pad_q_i;
            r_q_sync <= r_q_meta;
            r_q_prev <= r_q_sync;
            if (ce_i && !enable_i) begin
                r_acc  <= 8'd0;
                spin_o <= 8'd0;
            end else if (w_eval_ce) begin
                spin_o <= r_acc;
                r_acc  <= w_step_up ? 8'h01 : (w_step_dn ? 8'hFF : 8'h00);
            end else begin
                r_acc <= w_acc_sat;
            end
        end
    end
`endif

endmodule

`default_nettype wire
